// File: rtl/range_pkg.sv
// Shared definitions for the range-pair scorer: default widths, state encoding
// and the saturating counter increment.
package range_pkg;

  localparam int unsigned DEF_VAL_W = 8;
  localparam int unsigned DEF_CNT_W = 16;
  localparam int unsigned STATE_W   = 3;
  localparam int unsigned MAX_CNT_W = 32;

  localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] S_L_LO    = 3'd1;
  localparam logic [STATE_W-1:0] S_L_HI    = 3'd2;
  localparam logic [STATE_W-1:0] S_R_LO    = 3'd3;
  localparam logic [STATE_W-1:0] S_R_HI    = 3'd4;
  localparam logic [STATE_W-1:0] S_COMPARE = 3'd5;
  localparam logic [STATE_W-1:0] S_DONE    = 3'd6;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = S_IDLE,
    ST_L_LO    = S_L_LO,
    ST_L_HI    = S_L_HI,
    ST_R_LO    = S_R_LO,
    ST_R_HI    = S_R_HI,
    ST_COMPARE = S_COMPARE,
    ST_DONE    = S_DONE
  } state_e;

  // Returns {hit, next}: hit is set when the increment was attempted at max_val.
  function automatic logic [MAX_CNT_W:0] sat_inc(input logic [MAX_CNT_W-1:0] val,
                                                  input logic [MAX_CNT_W-1:0] max_val);
    logic [MAX_CNT_W:0] res;
    if (val >= max_val) begin
      res = {1'b1, max_val};
    end else begin
      res = {1'b0, val + MAX_CNT_W'(1)};
    end
    return res;
  endfunction

endpackage

// File: rtl/range_cmp.sv
// Combinational classification of one pair of inclusive ranges.
module range_cmp
  import range_pkg::*;
#(
  parameter int unsigned VAL_W = DEF_VAL_W
) (
  input  logic [VAL_W-1:0] l_lo_i,
  input  logic [VAL_W-1:0] l_hi_i,
  input  logic [VAL_W-1:0] r_lo_i,
  input  logic [VAL_W-1:0] r_hi_i,
  output logic             malformed_o,
  output logic             contain_o,
  output logic             overlap_o
);

  assign malformed_o = (l_lo_i > l_hi_i) | (r_lo_i > r_hi_i);
  assign contain_o   = ((l_lo_i <= r_lo_i) & (r_hi_i <= l_hi_i)) |
                       ((r_lo_i <= l_lo_i) & (l_hi_i <= r_hi_i));
  assign overlap_o   = (l_lo_i <= r_hi_i) & (r_lo_i <= l_hi_i);

endmodule

// File: rtl/range_pair_scorer.sv
// Streaming scorer: collects four bounds per pair over valid/ready and keeps
// saturating totals of contained, overlapping, well-formed and malformed pairs.
module range_pair_scorer
  import range_pkg::*;
#(
  parameter int unsigned VAL_W = DEF_VAL_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [VAL_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  output logic [CNT_W-1:0] sum_contain,
  output logic [CNT_W-1:0] sum_overlap,
  output logic [CNT_W-1:0] pair_count,
  output logic [CNT_W-1:0] bad_count,
  output logic             sat,
  output logic             busy,
  output logic             done
);

  localparam logic [MAX_CNT_W-1:0] CNT_MAX = MAX_CNT_W'((64'd1 << CNT_W) - 64'd1);

  state_e state_q, state_d;
  logic [VAL_W-1:0] l_lo_q, l_lo_d, l_hi_q, l_hi_d;
  logic [VAL_W-1:0] r_lo_q, r_lo_d, r_hi_q, r_hi_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] contain_q, contain_d, overlap_q, overlap_d;
  logic [CNT_W-1:0] pair_q, pair_d, bad_q, bad_d;
  logic             sat_q, sat_d;
  logic             in_ready_q, in_ready_d, busy_q, busy_d, done_q, done_d;

  logic             beat, trunc;
  logic             malformed, contain, overlap;
  logic [CNT_W:0]   inc_contain, inc_overlap, inc_pair, inc_bad;

  // Narrow wrapper around the package increment: {hit, next} at CNT_W bits.
  function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] v);
    logic [MAX_CNT_W:0] r;
    r = sat_inc(MAX_CNT_W'(v), CNT_MAX);
    return {r[MAX_CNT_W], CNT_W'(r[MAX_CNT_W-1:0])};
  endfunction

  assign inc_contain = bump(contain_q);
  assign inc_overlap = bump(overlap_q);
  assign inc_pair    = bump(pair_q);
  assign inc_bad     = bump(bad_q);

  range_cmp #(.VAL_W(VAL_W)) u_cmp (
    .l_lo_i      (l_lo_q),
    .l_hi_i      (l_hi_q),
    .r_lo_i      (r_lo_q),
    .r_hi_i      (r_hi_q),
    .malformed_o (malformed),
    .contain_o   (contain),
    .overlap_o   (overlap)
  );

  // in_ready_q is high exactly in the four GET states, so it qualifies a beat.
  assign beat  = in_valid & in_ready_q;
  assign trunc = beat & in_last &
                 ((state_q == ST_L_LO) | (state_q == ST_L_HI) | (state_q == ST_R_LO));

  always_comb begin
    state_d   = state_q;
    l_lo_d    = l_lo_q;
    l_hi_d    = l_hi_q;
    r_lo_d    = r_lo_q;
    r_hi_d    = r_hi_q;
    last_d    = last_q;
    contain_d = contain_q;
    overlap_d = overlap_q;
    pair_d    = pair_q;
    bad_d     = bad_q;
    sat_d     = sat_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          contain_d = '0;
          overlap_d = '0;
          pair_d    = '0;
          bad_d     = '0;
          sat_d     = 1'b0;
          state_d   = ST_L_LO;
        end
      end
      ST_L_LO: begin
        if (beat) begin
          l_lo_d  = in_data;
          state_d = in_last ? ST_DONE : ST_L_HI;
        end
      end
      ST_L_HI: begin
        if (beat) begin
          l_hi_d  = in_data;
          state_d = in_last ? ST_DONE : ST_R_LO;
        end
      end
      ST_R_LO: begin
        if (beat) begin
          r_lo_d  = in_data;
          state_d = in_last ? ST_DONE : ST_R_HI;
        end
      end
      ST_R_HI: begin
        if (beat) begin
          r_hi_d  = in_data;
          last_d  = in_last;
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (malformed) begin
          bad_d = inc_bad[CNT_W-1:0];
          sat_d = sat_d | inc_bad[CNT_W];
        end else begin
          pair_d = inc_pair[CNT_W-1:0];
          sat_d  = sat_d | inc_pair[CNT_W];
          if (contain) begin
            contain_d = inc_contain[CNT_W-1:0];
            sat_d     = sat_d | inc_contain[CNT_W];
          end
          if (overlap) begin
            overlap_d = inc_overlap[CNT_W-1:0];
            sat_d     = sat_d | inc_overlap[CNT_W];
          end
        end
        state_d = last_q ? ST_DONE : ST_L_LO;
      end
      default: state_d = ST_IDLE;
    endcase

    // A partial pair cut short by in_last is discarded and counted as bad.
    if (trunc) begin
      bad_d = inc_bad[CNT_W-1:0];
      sat_d = sat_d | inc_bad[CNT_W];
    end

    in_ready_d = (state_d == ST_L_LO) | (state_d == ST_L_HI) |
                 (state_d == ST_R_LO) | (state_d == ST_R_HI);
    busy_d     = in_ready_d | (state_d == ST_COMPARE);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      l_lo_q     <= '0;
      l_hi_q     <= '0;
      r_lo_q     <= '0;
      r_hi_q     <= '0;
      last_q     <= 1'b0;
      contain_q  <= '0;
      overlap_q  <= '0;
      pair_q     <= '0;
      bad_q      <= '0;
      sat_q      <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      l_lo_q     <= l_lo_d;
      l_hi_q     <= l_hi_d;
      r_lo_q     <= r_lo_d;
      r_hi_q     <= r_hi_d;
      last_q     <= last_d;
      contain_q  <= contain_d;
      overlap_q  <= overlap_d;
      pair_q     <= pair_d;
      bad_q      <= bad_d;
      sat_q      <= sat_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign sum_contain = contain_q;
  assign sum_overlap = overlap_q;
  assign pair_count  = pair_q;
  assign bad_count   = bad_q;
  assign sat         = sat_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_range_pair_scorer.sv
// Scoreboard bench for range_pair_scorer: a 16-bit and a 4-bit counter instance
// share one stimulus stream and are checked against a stream-level model.
module tb_range_pair_scorer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic        in_ready, sat, busy, done;
  logic [15:0] sum_contain, sum_overlap, pair_count, bad_count;
  logic        in_ready4, sat4, busy4, done4;
  logic [3:0]  contain4, overlap4, pair4, bad4;

  range_pair_scorer #(.VAL_W(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .sum_contain(sum_contain), .sum_overlap(sum_overlap),
    .pair_count(pair_count), .bad_count(bad_count),
    .sat(sat), .busy(busy), .done(done)
  );

  range_pair_scorer #(.VAL_W(8), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready4), .in_last(in_last),
    .sum_contain(contain4), .sum_overlap(overlap4),
    .pair_count(pair4), .bad_count(bad4),
    .sat(sat4), .busy(busy4), .done(done4)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; logic l; } beat_t;
  typedef struct { int unsigned c; int unsigned o; int unsigned p; int unsigned b; } res_t;

  beat_t       beats[$];
  res_t        exp_q[$];
  int unsigned n_total = 0;
  int unsigned n_bad = 0;
  int unsigned viol = 0;
  int unsigned cyc = 0;
  int unsigned done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake invariants sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_ready && !busy) viol <= viol + 1;
      if (busy && done) viol <= viol + 1;
      if (in_ready !== in_ready4) viol <= viol + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned lim4(input int unsigned x);
    return (x > 15) ? 15 : x;
  endfunction

  // Stall-free reference: walks the beat stream four bounds at a time.
  function automatic res_t model_run();
    res_t r;
    logic [7:0] v[4];
    int pos;
    r.c = 0; r.o = 0; r.p = 0; r.b = 0;
    pos = 0;
    for (int i = 0; i < beats.size(); i++) begin
      v[pos] = beats[i].d;
      if (pos < 3 && beats[i].l) begin
        r.b++;
        break;
      end
      if (pos == 3) begin
        if (v[0] > v[1] || v[2] > v[3]) begin
          r.b++;
        end else begin
          r.p++;
          if ((v[0] <= v[2] && v[3] <= v[1]) || (v[2] <= v[0] && v[1] <= v[3])) r.c++;
          if (v[0] <= v[3] && v[2] <= v[1]) r.o++;
        end
        pos = 0;
        if (beats[i].l) break;
      end else begin
        pos++;
      end
    end
    return r;
  endfunction

  task automatic add_pair(input int a, input int b, input int c, input int d, input bit last);
    beats.push_back('{d: 8'(a), l: 1'b0});
    beats.push_back('{d: 8'(b), l: 1'b0});
    beats.push_back('{d: 8'(c), l: 1'b0});
    beats.push_back('{d: 8'(d), l: last});
  endtask

  task automatic send_beat(input logic [7:0] d, input logic lst, input int gap);
    int n;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (gap) @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = lst;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("beat_ready_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_start(input bit with_valid);
    if (with_valid) begin
      in_valid = 1'b1;
      in_data  = 8'hAA;
    end
    start = 1'b1;
    chk("idle_ready", in_ready, 0);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
  endtask

  task automatic drive_stream(input int max_gap);
    exp_q.push_back(model_run());
    for (int i = 0; i < beats.size(); i++)
      send_beat(beats[i].d, beats[i].l, $urandom_range(0, max_gap));
  endtask

  task automatic finish_run(input string tag);
    res_t r;
    int n;
    n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    done_cyc = cyc;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_done4"}, done4, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sb_depth"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      chk({tag, "_contain"}, sum_contain, r.c);
      chk({tag, "_overlap"}, sum_overlap, r.o);
      chk({tag, "_pairs"},   pair_count,  r.p);
      chk({tag, "_bad"},     bad_count,   r.b);
      chk({tag, "_sat"},     sat, (r.c > 65535 || r.o > 65535 || r.p > 65535 || r.b > 65535));
      chk({tag, "_contain4"}, contain4, lim4(r.c));
      chk({tag, "_overlap4"}, overlap4, lim4(r.o));
      chk({tag, "_pairs4"},   pair4,    lim4(r.p));
      chk({tag, "_bad4"},     bad4,     lim4(r.b));
      chk({tag, "_sat4"},     sat4, (r.c > 15 || r.o > 15 || r.p > 15 || r.b > 15));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0;

    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sat", sat, 0);
    chk("rst_pairs", pair_count, 0);
    chk("rst_contain", sum_contain, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reference puzzle, start issued together with a valid beat.
    beats.delete();
    add_pair(2, 4, 6, 8, 0);
    add_pair(2, 3, 4, 5, 0);
    add_pair(5, 7, 7, 9, 0);
    add_pair(2, 8, 3, 7, 0);
    add_pair(6, 6, 4, 6, 0);
    add_pair(2, 6, 4, 8, 1);
    c0 = cyc;
    pulse_start(1);
    drive_stream(0);
    finish_run("t1");
    chk("t1_contain_k", sum_contain, 2);
    chk("t1_overlap_k", sum_overlap, 4);
    chk("t1_pairs_k", pair_count, 6);
    chk("t1_bad_k", bad_count, 0);
    chk("t1_cycles", done_cyc - c0, 31);

    // Malformed pair followed by an equal-bounds pair, restarted from DONE.
    beats.delete();
    add_pair(5, 3, 1, 2, 0);
    add_pair(1, 1, 1, 1, 1);
    pulse_start(0);
    drive_stream(0);
    finish_run("t2");
    chk("t2_bad_k", bad_count, 1);
    chk("t2_pairs_k", pair_count, 1);
    chk("t2_contain_k", sum_contain, 1);
    chk("t2_overlap_k", sum_overlap, 1);

    // Truncation on the r_lo beat of the second pair.
    beats.delete();
    add_pair(1, 4, 2, 3, 0);
    beats.push_back('{d: 8'd5, l: 1'b0});
    beats.push_back('{d: 8'd6, l: 1'b0});
    beats.push_back('{d: 8'd7, l: 1'b1});
    pulse_start(0);
    drive_stream(0);
    chk("t3_done_next", done, 1);
    chk("t3_busy_next", busy, 0);
    finish_run("t3");
    in_valid = 1'b1;
    in_data  = 8'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_no_accept", in_ready, 0);
    end
    in_valid = 1'b0;
    chk("t3_pairs_hold", pair_count, 1);
    chk("t3_bad_hold", bad_count, 1);

    // 100 random pairs with random in_valid gaps.
    beats.delete();
    for (int i = 0; i < 100; i++)
      add_pair($urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 15), $urandom_range(0, 15), (i == 99));
    pulse_start(0);
    drive_stream(2);
    finish_run("t4");

    // Saturation of the narrow instance, then clear on restart.
    beats.delete();
    for (int i = 0; i < 20; i++) add_pair(1, 5, 2, 3, (i == 19));
    pulse_start(0);
    drive_stream(0);
    finish_run("t5");
    chk("t5_contain4_k", contain4, 15);
    chk("t5_sat4_k", sat4, 1);
    chk("t5_contain_k", sum_contain, 20);
    pulse_start(0);
    chk("t5_clr_contain4", contain4, 0);
    chk("t5_clr_pairs4", pair4, 0);
    chk("t5_clr_sat4", sat4, 0);
    chk("t5_clr_contain", sum_contain, 0);

    // Asynchronous reset in R_LO after one scored pair.
    send_beat(8'd2, 1'b0, 0);
    send_beat(8'd5, 1'b0, 0);
    send_beat(8'd3, 1'b0, 0);
    send_beat(8'd4, 1'b0, 0);
    send_beat(8'd8, 1'b0, 0);
    send_beat(8'd9, 1'b0, 0);
    chk("t6_pre_pairs", pair_count, 1);
    chk("t6_pre_ready", in_ready, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", in_ready, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_pairs", pair_count, 0);
    chk("t6_rst_contain", sum_contain, 0);
    chk("t6_rst_ready4", in_ready4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    beats.delete();
    add_pair(1, 2, 7, 9, 1);
    pulse_start(0);
    drive_stream(0);
    finish_run("t6");

    chk("handshake_invariants", viol, 0);
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
